wb_port_arbiter: RTL

Shares the register file's single write port between two writeback requesters: source 0 (ALU result) and source 1 (memory load result). Each source has a one-entry holding register with a valid/ready handshake. An age-ordered grant drives a registered write port (`writeEnable`/`writeAddr`/`writeValue`) straight into the register file. Two query ports report whether a register has a write still in flight, so decode can stall on read-after-write hazards.

---
 rtl/wb_port_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-source writeback arbiter for the register file write port
//
// Purpose: arbitrates the single register-file write port between source 0
// (ALU result) and source 1 (memory load result). Each source owns a one-entry
// holding register. Full entries are granted oldest-first, one per cycle, into
// a registered write stage. Two query ports flag registers with a write in flight.
//
// Ports:
//   clk                      clock, rising-edge state updates
//   rst                      asynchronous active-low reset
//   valid0/1, ready0/1       per-source handshake
//   addr0/1, value0/1        per-source destination register and data
//   writeEnable/Addr/Value   registered write port to the register file
//   queryAddr1/2, busy1/2    read-after-write hazard query from decode
module wb_port_arbiter #(
    parameter int WORD_WIDTH  = 32,
    parameter int REG_NUM_LOG = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid0,
    output logic                   ready0,
    input  logic [REG_NUM_LOG-1:0] addr0,
    input  logic [WORD_WIDTH-1:0]  value0,
    input  logic                   valid1,
    output logic                   ready1,
    input  logic [REG_NUM_LOG-1:0] addr1,
    input  logic [WORD_WIDTH-1:0]  value1,
    output logic                   writeEnable,
    output logic [REG_NUM_LOG-1:0] writeAddr,
    output logic [WORD_WIDTH-1:0]  writeValue,
    input  logic [REG_NUM_LOG-1:0] queryAddr1,
    input  logic [REG_NUM_LOG-1:0] queryAddr2,
    output logic                   busy1,
    output logic                   busy2
);

    logic                   full0, full1;
    // older = 1 means the source 1 entry arrived first (only meaningful when both are full)
    logic                   older;
    logic [REG_NUM_LOG-1:0] held_addr0, held_addr1;
    logic [WORD_WIDTH-1:0]  held_value0, held_value1;

    logic                   grant0, grant1, grant_any;
    logic [REG_NUM_LOG-1:0] grant_addr;
    logic [WORD_WIDTH-1:0]  grant_value;
    logic                   accept0, accept1;
    logic                   stay1;

    assign grant0    = full0 && (!full1 || !older);
    assign grant1    = full1 && (!full0 || older);
    assign grant_any = grant0 || grant1;

    assign grant_addr  = grant1 ? held_addr1  : held_addr0;
    assign grant_value = grant1 ? held_value1 : held_value0;

    // A granted entry drains on this edge, so it may be refilled on the same edge.
    assign ready0  = rst && (!full0 || grant0);
    assign ready1  = rst && (!full1 || grant1);
    assign accept0 = valid0 && ready0;
    assign accept1 = valid1 && ready1;

    // Source 1 is older next cycle only if its entry survives this edge untouched;
    // a surviving source 0 entry or two fresh fills both leave source 0 older.
    assign stay1 = full1 && !grant1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full0       <= 1'b0;
            full1       <= 1'b0;
            older       <= 1'b0;
            writeEnable <= 1'b0;
            writeAddr   <= '0;
            writeValue  <= '0;
        end else begin
            full0       <= accept0 || (full0 && !grant0);
            full1       <= accept1 || (full1 && !grant1);
            older       <= stay1;
            // Writes to the zero register still use their slot but never strobe.
            writeEnable <= grant_any && (grant_addr != '0);
            if (grant_any) begin
                writeAddr  <= grant_addr;
                writeValue <= grant_value;
            end
        end
    end

    // Holding data needs no reset: it is only observed while the matching full flag is set.
    always_ff @(posedge clk) begin
        if (accept0) begin
            held_addr0  <= addr0;
            held_value0 <= value0;
        end
        if (accept1) begin
            held_addr1  <= addr1;
            held_value1 <= value1;
        end
    end

    // The writeEnable term keeps busy high through the register file's falling-edge commit.
    assign busy1 = (queryAddr1 != '0) &&
                   ((full0 && held_addr0 == queryAddr1) ||
                    (full1 && held_addr1 == queryAddr1) ||
                    (writeEnable && writeAddr == queryAddr1));
    assign busy2 = (queryAddr2 != '0) &&
                   ((full0 && held_addr0 == queryAddr2) ||
                    (full1 && held_addr1 == queryAddr2) ||
                    (writeEnable && writeAddr == queryAddr2));

endmodule
